// File: rtl/bn_ctrl_pkg.sv
// Shared types and default sizes for the BN parameter controller.
// Optional readback port is enabled with BN_PARAM_READBACK_EN (see bn_param_ctrl).
package bn_ctrl_pkg;

  localparam int BN_PARA_WIDTH  = 16;
  localparam int BN_CHANNEL_NUM = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } bn_state_e;

endpackage

// File: rtl/bn_param_bank.sv
// Double-buffered BN coefficient storage: per-channel shadow write port,
// whole-set copy into the active arrays on a swap strobe.
module bn_param_bank
  import bn_ctrl_pkg::*;
#(
  parameter int PARA_WIDTH  = BN_PARA_WIDTH,
  parameter int CHANNEL_NUM = BN_CHANNEL_NUM,
  localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                wr_en,
  input  logic [CW-1:0]                       wr_idx,
  input  logic signed [PARA_WIDTH-1:0]        wr_a,
  input  logic signed [PARA_WIDTH-1:0]        wr_b,
  input  logic                                swap,
  output logic [CHANNEL_NUM*PARA_WIDTH-1:0]   act_a,
  output logic [CHANNEL_NUM*PARA_WIDTH-1:0]   act_b
);

  logic signed [PARA_WIDTH-1:0]        r_sh_a [CHANNEL_NUM];
  logic signed [PARA_WIDTH-1:0]        r_sh_b [CHANNEL_NUM];
  logic [CHANNEL_NUM*PARA_WIDTH-1:0]   r_act_a;
  logic [CHANNEL_NUM*PARA_WIDTH-1:0]   r_act_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        r_sh_a[i] <= '0;
        r_sh_b[i] <= '0;
      end
    end else if (wr_en) begin
      r_sh_a[wr_idx] <= wr_a;
      r_sh_b[wr_idx] <= wr_b;
    end
  end

  // Active set only ever changes here, so it holds steady for a whole layer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_act_a <= '0;
      r_act_b <= '0;
    end else if (swap) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        r_act_a[i*PARA_WIDTH +: PARA_WIDTH] <= r_sh_a[i];
        r_act_b[i*PARA_WIDTH +: PARA_WIDTH] <= r_sh_b[i];
      end
    end
  end

  assign act_a = r_act_a;
  assign act_b = r_act_b;

endmodule

// File: rtl/bn_param_ctrl.sv
// BN parameter load/commit controller; define BN_PARAM_READBACK_EN to add the
// registered rd_ch/rd_a/rd_b readback port on the active set.
//
// state | meaning
// IDLE  | no load in progress; swap_req here is an error
// LOAD  | accepting beats into shadow[counter]; cfg_start restarts at channel 0
// FULL  | shadow complete, waiting for swap_req to commit it
module bn_param_ctrl
  import bn_ctrl_pkg::*;
#(
  parameter int PARA_WIDTH  = BN_PARA_WIDTH,
  parameter int CHANNEL_NUM = BN_CHANNEL_NUM,
  localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                cfg_start,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic signed [PARA_WIDTH-1:0]        cfg_a,
  input  logic signed [PARA_WIDTH-1:0]        cfg_b,
  input  logic                                swap_req,
  output logic [CHANNEL_NUM*PARA_WIDTH-1:0]   bn_a,
  output logic [CHANNEL_NUM*PARA_WIDTH-1:0]   bn_b,
  output logic                                param_valid,
  output logic                                shadow_full,
  output logic                                swap_err
`ifdef BN_PARAM_READBACK_EN
  ,
  input  logic [CW-1:0]                       rd_ch,
  output logic signed [PARA_WIDTH-1:0]        rd_a,
  output logic signed [PARA_WIDTH-1:0]        rd_b
`endif
);

  localparam logic [CW-1:0] CNT_LAST = CW'(CHANNEL_NUM - 1);

  bn_state_e       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_wr_en;
  logic            w_swap;
  logic            r_param_valid;
  logic            r_swap_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
        end
      end
      LOAD: begin
        // A restart wins over a coincident beat, which is dropped.
        if (cfg_start) begin
          w_cnt_nxt = '0;
        end else if (cfg_valid) begin
          w_wr_en = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = FULL;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      FULL: begin
        if (swap_req) begin
          w_swap      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_param_valid <= 1'b0;
      r_swap_err    <= 1'b0;
    end else begin
      if (w_swap) r_param_valid <= 1'b1;
      if (swap_req && (r_state != FULL)) r_swap_err <= 1'b1;
    end
  end

  assign cfg_ready   = (r_state == LOAD);
  assign shadow_full = (r_state == FULL);
  assign param_valid = r_param_valid;
  assign swap_err    = r_swap_err;

  bn_param_bank #(
    .PARA_WIDTH  (PARA_WIDTH),
    .CHANNEL_NUM (CHANNEL_NUM)
  ) u_bank (
    .clk    (clk),
    .rstn   (rstn),
    .wr_en  (w_wr_en),
    .wr_idx (r_cnt),
    .wr_a   (cfg_a),
    .wr_b   (cfg_b),
    .swap   (w_swap),
    .act_a  (bn_a),
    .act_b  (bn_b)
  );

`ifdef BN_PARAM_READBACK_EN
  logic signed [PARA_WIDTH-1:0] r_rd_a, r_rd_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      r_rd_a <= bn_a[int'(rd_ch)*PARA_WIDTH +: PARA_WIDTH];
      r_rd_b <= bn_b[int'(rd_ch)*PARA_WIDTH +: PARA_WIDTH];
    end
  end

  assign rd_a = r_rd_a;
  assign rd_b = r_rd_b;
`endif

endmodule

// File: tb/tb_bn_param_ctrl.sv
// Self-checking bench for bn_param_ctrl with CHANNEL_NUM=4; expected active
// sets are queued when a swap is driven and compared once it takes effect.
module tb_bn_param_ctrl;

  localparam int PW = 16;
  localparam int CN = 4;
  localparam int CW = 2;
  localparam int VW = PW * CN;

  typedef struct packed {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 cfg_start = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 swap_req = 1'b0;
  logic signed [PW-1:0] cfg_a = '0;
  logic signed [PW-1:0] cfg_b = '0;
  logic                 cfg_ready;
  logic [VW-1:0]        bn_a, bn_b;
  logic                 param_valid, shadow_full, swap_err;
`ifdef BN_PARAM_READBACK_EN
  logic [CW-1:0]        rd_ch = '0;
  logic signed [PW-1:0] rd_a, rd_b;
`endif

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bn_param_ctrl #(.PARA_WIDTH(PW), .CHANNEL_NUM(CN)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_a       (cfg_a),
    .cfg_b       (cfg_b),
    .swap_req    (swap_req),
    .bn_a        (bn_a),
    .bn_b        (bn_b),
    .param_valid (param_valid),
    .shadow_full (shadow_full),
    .swap_err    (swap_err)
`ifdef BN_PARAM_READBACK_EN
    ,
    .rd_ch       (rd_ch),
    .rd_a        (rd_a),
    .rd_b        (rd_b)
`endif
  );

  function automatic logic [VW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [VW-1:0] r;
    r[0*PW +: PW] = PW'(v0);
    r[1*PW +: PW] = PW'(v1);
    r[2*PW +: PW] = PW'(v2);
    r[3*PW +: PW] = PW'(v3);
    return r;
  endfunction

  // One clock of stimulus; inputs return to 0 just after the edge.
  task automatic cyc(input logic st, input logic vld, input logic sw, input int a, input int b);
    cfg_start = st;
    cfg_valid = vld;
    swap_req  = sw;
    cfg_a     = PW'(a);
    cfg_b     = PW'(b);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    swap_req  = 1'b0;
  endtask

  task automatic push_exp(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    exp_t x;
    x.a = pack4(a0, a1, a2, a3);
    x.b = pack4(b0, b1, b2, b3);
    sb_q.push_back(x);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 5, 5);
    checks++;
    if (bn_a !== '0 || bn_b !== '0) begin
      errors++; $display("FAIL reset_arrays bn_a=%h bn_b=%h expected 0", bn_a, bn_b);
    end
    checks++;
    if ({param_valid, cfg_ready, swap_err, shadow_full} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got pv/rdy/err/full=%b expected 0000",
                         {param_valid, cfg_ready, swap_err, shadow_full});
    end
`ifdef BN_PARAM_READBACK_EN
    checks++;
    if (rd_a !== '0 || rd_b !== '0) begin
      errors++; $display("FAIL reset_readback rd_a=%0d rd_b=%0d expected 0", rd_a, rd_b);
    end
`endif
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (bn_a !== '0 || bn_b !== '0) begin
      errors++; $display("FAIL idle_arrays bn_a=%h bn_b=%h expected 0", bn_a, bn_b);
    end
    checks++;
    if ({param_valid, cfg_ready, swap_err, shadow_full} !== 4'b0000) begin
      errors++; $display("FAIL idle_flags got pv/rdy/err/full=%b expected 0000",
                         {param_valid, cfg_ready, swap_err, shadow_full});
    end
  endtask

  task automatic test_load_swap();
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready got %b expected 1", cfg_ready);
    end
    for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b1, 1'b0, i, 10 * i);
    checks++;
    if (shadow_full !== 1'b0) begin
      errors++; $display("FAIL full_early got %b expected 0", shadow_full);
    end
    cyc(1'b0, 1'b1, 1'b0, 4, 40);
    checks++;
    if (shadow_full !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL full_after_beat4 full=%b ready=%b expected 1 0", shadow_full, cfg_ready);
    end
    checks++;
    if (bn_a !== '0) begin
      errors++; $display("FAIL active_before_swap bn_a=%h expected 0", bn_a);
    end
    push_exp(1, 2, 3, 4, 10, 20, 30, 40);
    cyc(1'b0, 1'b0, 1'b1, 0, 0);
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL sb_empty load_swap size=0 expected 1");
    end else begin
      e = sb_q.pop_front();
      if (bn_a !== e.a || bn_b !== e.b) begin
        errors++; $display("FAIL load_swap bn_a=%h bn_b=%h expected %h %h", bn_a, bn_b, e.a, e.b);
      end
    end
    checks++;
    if (param_valid !== 1'b1 || shadow_full !== 1'b0) begin
      errors++; $display("FAIL swap_flags pv=%b full=%b expected 1 0", param_valid, shadow_full);
    end
  endtask

`ifdef BN_PARAM_READBACK_EN
  task automatic test_readback();
    rd_ch = 2'd2;
    @(posedge clk); #1;
    checks++;
    if (rd_a !== 16'sd3 || rd_b !== 16'sd30) begin
      errors++; $display("FAIL readback_ch2 rd_a=%0d rd_b=%0d expected 3 30", rd_a, rd_b);
    end
    rd_ch = 2'd0;
    @(posedge clk); #1;
    checks++;
    if (rd_a !== 16'sd1 || rd_b !== 16'sd10) begin
      errors++; $display("FAIL readback_ch0 rd_a=%0d rd_b=%0d expected 1 10", rd_a, rd_b);
    end
  endtask
`endif

  task automatic test_abort();
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 99, 990);
    cyc(1'b0, 1'b1, 1'b0, 98, 980);
    cyc(1'b1, 1'b1, 1'b0, 77, 770);
    cyc(1'b0, 1'b1, 1'b0, 5, 50);
    cyc(1'b0, 1'b1, 1'b0, 6, 60);
    checks++;
    if (shadow_full !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL abort_counter full=%b ready=%b expected 0 1", shadow_full, cfg_ready);
    end
    cyc(1'b0, 1'b1, 1'b0, 7, 70);
    cyc(1'b0, 1'b1, 1'b0, 8, 80);
    checks++;
    if (shadow_full !== 1'b1) begin
      errors++; $display("FAIL abort_full got %b expected 1", shadow_full);
    end
    checks++;
    if (bn_a !== pack4(1, 2, 3, 4)) begin
      errors++; $display("FAIL active_stable bn_a=%h expected %h", bn_a, pack4(1, 2, 3, 4));
    end
    push_exp(5, 6, 7, 8, 50, 60, 70, 80);
    cyc(1'b0, 1'b0, 1'b1, 0, 0);
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL sb_empty abort size=0 expected 1");
    end else begin
      e = sb_q.pop_front();
      if (bn_a !== e.a || bn_b !== e.b) begin
        errors++; $display("FAIL abort_swap bn_a=%h bn_b=%h expected %h %h", bn_a, bn_b, e.a, e.b);
      end
    end
  endtask

  task automatic test_valid_toggle();
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cyc(1'b0, 1'b1, 1'b0, 21 + i / 2, -(1 + i / 2));
      else            cyc(1'b0, 1'b0, 1'b0, 16'h7777, 16'h1234);
      if (i == 1) begin
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++; $display("FAIL toggle_ready got %b expected 1", cfg_ready);
        end
      end
      if (i == 5) begin
        checks++;
        if (shadow_full !== 1'b0) begin
          errors++; $display("FAIL toggle_3beats full=%b expected 0", shadow_full);
        end
      end
    end
    checks++;
    if (shadow_full !== 1'b1) begin
      errors++; $display("FAIL toggle_4beats full=%b expected 1", shadow_full);
    end
    cyc(1'b1, 1'b1, 1'b0, 55, 55);
    checks++;
    if (shadow_full !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL start_in_full full=%b ready=%b expected 1 0", shadow_full, cfg_ready);
    end
    push_exp(21, 22, 23, 24, -1, -2, -3, -4);
    cyc(1'b0, 1'b0, 1'b1, 0, 0);
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL sb_empty toggle size=0 expected 1");
    end else begin
      e = sb_q.pop_front();
      if (bn_a !== e.a || bn_b !== e.b) begin
        errors++; $display("FAIL toggle_swap bn_a=%h bn_b=%h expected %h %h", bn_a, bn_b, e.a, e.b);
      end
    end
  endtask

  task automatic test_swap_err();
    checks++;
    if (swap_err !== 1'b0) begin
      errors++; $display("FAIL err_clean got %b expected 0", swap_err);
    end
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 31, 310);
    cyc(1'b0, 1'b0, 1'b1, 0, 0);
    checks++;
    if (swap_err !== 1'b1 || cfg_ready !== 1'b1 || bn_a !== pack4(21, 22, 23, 24)) begin
      errors++; $display("FAIL swap_in_load err=%b ready=%b bn_a=%h expected 1 1 %h",
                         swap_err, cfg_ready, bn_a, pack4(21, 22, 23, 24));
    end
    // Reset in the middle of a partial load.
    cyc(1'b0, 1'b1, 1'b0, 32, 320);
    rstn = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (swap_err !== 1'b0 || param_valid !== 1'b0 || bn_a !== '0 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL midload_reset err=%b pv=%b ready=%b bn_a=%h expected 0 0 0 0",
                         swap_err, param_valid, cfg_ready, bn_a);
    end
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 40 + i, 400 + 10 * i);
    checks++;
    if (shadow_full !== 1'b0) begin
      errors++; $display("FAIL reload_3beats full=%b expected 0", shadow_full);
    end
    cyc(1'b0, 1'b1, 1'b1, 43, 430);
    checks++;
    if (shadow_full !== 1'b1 || swap_err !== 1'b1 || bn_a !== '0 || param_valid !== 1'b0) begin
      errors++; $display("FAIL swap_on_last_beat full=%b err=%b pv=%b bn_a=%h expected 1 1 0 0",
                         shadow_full, swap_err, param_valid, bn_a);
    end
    push_exp(40, 41, 42, 43, 400, 410, 420, 430);
    cyc(1'b0, 1'b0, 1'b1, 0, 0);
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL sb_empty err_commit size=0 expected 1");
    end else begin
      e = sb_q.pop_front();
      if (bn_a !== e.a || bn_b !== e.b || param_valid !== 1'b1 || swap_err !== 1'b1) begin
        errors++; $display("FAIL err_commit bn_a=%h bn_b=%h pv=%b err=%b expected %h %h 1 1",
                           bn_a, bn_b, param_valid, swap_err, e.a, e.b);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 0, 0);
    checks++;
    if (bn_a !== pack4(40, 41, 42, 43) || swap_err !== 1'b1) begin
      errors++; $display("FAIL swap_in_idle bn_a=%h err=%b expected %h 1",
                         bn_a, swap_err, pack4(40, 41, 42, 43));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_swap();
`ifdef BN_PARAM_READBACK_EN
    test_readback();
`endif
    test_abort();
    test_valid_toggle();
    test_swap_err();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover size=%0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bn_param_ctrl.md
BN_PARAM_CTRL -- requirements
Module: bn_param_ctrl

Interface
REQ-001 SHALL have parameter PARA_WIDTH, default 16, the width of each signed BN coefficient.
REQ-002 SHALL have parameter CHANNEL_NUM, default 128, the number of channels per parameter set.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_start, input, 1 bit: a pulse that begins loading a new parameter set.
REQ-006 SHALL have port cfg_valid, input, 1 bit: the loader beat is valid.
REQ-007 SHALL have port cfg_ready, output, 1 bit: the controller accepts a beat.
REQ-008 SHALL have port cfg_a, input, signed PARA_WIDTH: the bn_a value for the current channel.
REQ-009 SHALL have port cfg_b, input, signed PARA_WIDTH: the bn_b value for the current channel.
REQ-010 SHALL have port swap_req, input, 1 bit: the layer-boundary pulse that commits the shadow set.
REQ-011 SHALL have port bn_a, output, signed PARA_WIDTH x CHANNEL_NUM: the active coefficient set, driven to the BN/residual datapath.
REQ-012 SHALL have port bn_b, output, signed PARA_WIDTH x CHANNEL_NUM: the active offset set.
REQ-013 SHALL have port param_valid, output, 1 bit: the active set has been committed at least once.
REQ-014 SHALL have port shadow_full, output, 1 bit: the shadow set is complete and awaiting swap.
REQ-015 SHALL have port swap_err, output, 1 bit: a sticky flag set when swap_req arrives while the controller is not in FULL.

Function
REQ-016 SHALL implement a state machine with states IDLE, LOAD and FULL.
REQ-017 In IDLE, cfg_start SHALL move the machine to LOAD on the next edge and clear the channel counter to 0.
REQ-018 SHALL assert cfg_ready only in LOAD.
REQ-019 On each beat with cfg_valid and cfg_ready high, SHALL write cfg_a and cfg_b into shadow[counter] and increment the counter.
REQ-020 The beat with counter equal to CHANNEL_NUM-1 SHALL move the machine to FULL; the counter SHALL then return to 0.
REQ-021 cfg_start in LOAD SHALL abort the load: counter back to 0, state stays LOAD, and any beat in that same cycle is discarded.
REQ-022 cfg_start in FULL SHALL be ignored.
REQ-023 shadow_full SHALL be high exactly while the state is FULL.
REQ-024 swap_req in FULL SHALL copy all shadow entries into the active arrays at that edge, set param_valid, and return to IDLE.
REQ-025 The new active values SHALL be visible on bn_a/bn_b in the cycle after the swap edge (latency 1).
REQ-026 swap_req in IDLE or LOAD SHALL leave the active arrays unchanged and set swap_err.
REQ-027 swap_req in the same cycle as the final load beat SHALL count as not-FULL: no swap occurs and swap_err is set.
REQ-028 The active arrays SHALL change only on a swap, so they are stable through a whole layer.
REQ-029 The counter SHALL be $clog2(CHANNEL_NUM) bits wide and SHALL never exceed CHANNEL_NUM-1.

Reset
REQ-030 While rstn is low, the state SHALL be IDLE, the counter 0, all active and shadow entries 0, and param_valid, shadow_full, swap_err and cfg_ready 0.
REQ-031 Reset asserted mid-load SHALL discard the partial shadow set, with no swap possible until a new full load completes.
REQ-032 swap_err SHALL clear only on reset.

Configuration
REQ-033 When BN_PARAM_READBACK_EN is defined, SHALL add input rd_ch ($clog2(CHANNEL_NUM) bits) and outputs rd_a and rd_b (PARA_WIDTH each).
REQ-034 rd_a and rd_b SHALL carry the registered active[rd_ch] values one cycle after rd_ch is presented, and 0 under reset.
REQ-035 When BN_PARAM_READBACK_EN is undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 Package bn_ctrl_pkg SHALL hold the state enum type (IDLE/LOAD/FULL) and the default CHANNEL_NUM and PARA_WIDTH constants.
REQ-037 The double-buffered storage SHALL be a sub-module bn_param_bank (shadow write port, swap strobe, active outputs); the FSM and counter stay in bn_param_ctrl.

Verification (bench may use CHANNEL_NUM=4)
REQ-038 Reset then idle: bn_a and bn_b all 0; param_valid, cfg_ready and swap_err all 0.
REQ-039 cfg_start, 4 beats a={1,2,3,4} b={10,20,30,40}, then swap_req: shadow_full rises after beat 4; bn_a={1,2,3,4} and bn_b={10,20,30,40} one cycle after the swap; param_valid=1.
REQ-040 Load 2 beats, cfg_start, then 4 beats a={5,6,7,8}: after swap, bn_a={5,6,7,8} with no residue from the aborted load.
REQ-041 swap_req pulsed during LOAD and coincident with the final beat: active arrays unchanged and swap_err=1; a later swap in FULL still commits.
REQ-042 cfg_valid toggling 1,0,1,0: the counter advances only on accepted beats; cfg_start in FULL is ignored and shadow_full stays 1.
REQ-043 With BN_PARAM_READBACK_EN defined, after the REQ-039 load, rd_ch=2 gives rd_a=3 and rd_b=30 one cycle later.
